// File: rtl/crt_2011_pkg.sv
// Shared constants, state encoding and modular helpers for the 2011/2048
// residue-to-binary converter.
package crt_2011_pkg;

    localparam int IW = 11;
    localparam int XW = 22;

    localparam logic [IW-1:0] M1    = 11'd2011;
    localparam logic [IW-1:0] INV   = 11'd924;
    localparam logic [XW-1:0] MAX_X = 22'd4118527;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    // One conditional subtraction of 2011; exact for any input below 2*2011.
    function automatic logic [IW-1:0] red_2011(input logic [IW:0] v);
        logic [IW:0] t;
        t = (v >= {1'b0, M1}) ? (v - {1'b0, M1}) : v;
        return t[IW-1:0];
    endfunction

endpackage

// File: rtl/crt_2011_2048_to_bin_dbl_add.sv
// One double-and-add step of the MSB-first modular multiply by INV.
// Keeps the accumulator below 2011 whenever acc and d are below 2011.
module mod_2011_dbl_add
    import crt_2011_pkg::*;
(
    input  logic [IW-1:0] acc,
    input  logic [IW-1:0] d,
    input  logic          inv_bit,
    output logic [IW-1:0] nxt
);

    logic [IW-1:0] dbl_s;
    logic [IW:0]   sum_s;

    // Double then conditionally add d, reducing after each operation.
    always_comb begin
        dbl_s = red_2011({acc, 1'b0});
        if (inv_bit) begin
            sum_s = {1'b0, dbl_s} + {1'b0, d};
        end else begin
            sum_s = {1'b0, dbl_s};
        end
        nxt = red_2011(sum_s);
    end

endmodule

// File: rtl/crt_2011_2048_to_bin.sv
// Sequential CRT converter: (X mod 2011, X mod 2048) -> X, fixed 12-cycle
// latency, one conversion in flight, valid/ready on both sides.
module crt_2011_2048_to_bin
    import crt_2011_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] r1,
    input  logic [IW-1:0] r2,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [XW-1:0] out_x,
    output logic          out_err
);

    state_t        state_r, state_s;
    logic [IW-1:0] r1_r, r1_s;
    logic [IW-1:0] r2_r, r2_s;
    logic          err_r, err_s;
    logic [IW-1:0] d_r, d_s;
    logic [IW-1:0] acc_r, acc_s;
    logic [3:0]    k_r, k_s;
    logic          out_valid_r, out_valid_s;
    logic [XW-1:0] out_x_r, out_x_s;
    logic          out_err_r, out_err_s;

    logic [IW-1:0] r2m_s;
    logic [IW:0]   diff_s;
    logic          inv_bit_s;
    logic [IW-1:0] step_s;

    mod_2011_dbl_add u_dbl_add (
        .acc     (acc_r),
        .d       (d_r),
        .inv_bit (inv_bit_s),
        .nxt     (step_s)
    );

    // Next-state and datapath update for the accept/prep/multiply/handoff FSM.
    always_comb begin
        state_s     = state_r;
        r1_s        = r1_r;
        r2_s        = r2_r;
        err_s       = err_r;
        d_s         = d_r;
        acc_s       = acc_r;
        k_s         = k_r;
        out_valid_s = out_valid_r;
        out_x_s     = out_x_r;
        out_err_s   = out_err_r;

        inv_bit_s = INV[k_r];
        r2m_s     = red_2011({1'b0, r2_r});
        // An illegal r1 can exceed 2010 here; the final reduction keeps the
        // multiply loop in range even though the result is discarded.
        if (r1_r >= r2m_s) begin
            diff_s = {1'b0, r1_r} - {1'b0, r2m_s};
        end else begin
            diff_s = {1'b0, r1_r} + {1'b0, M1} - {1'b0, r2m_s};
        end

        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    r1_s    = r1;
                    r2_s    = r2;
                    err_s   = (r1 >= M1);
                    state_s = PREP;
                end else begin
                    state_s = IDLE;
                end
            end
            PREP: begin
                d_s     = red_2011(diff_s);
                acc_s   = 11'd0;
                k_s     = 4'd10;
                state_s = MUL;
            end
            MUL: begin
                acc_s = step_s;
                if (k_r == 4'd0) begin
                    k_s         = 4'd10;
                    state_s     = DONE;
                    out_valid_s = 1'b1;
                    out_err_s   = err_r;
                    out_x_s     = err_r ? 22'd0 : {step_s, r2_r};
                end else begin
                    k_s = k_r - 4'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s     = IDLE;
                    out_valid_s = 1'b0;
                    out_x_s     = 22'd0;
                    out_err_s   = 1'b0;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and data registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            r1_r        <= 11'd0;
            r2_r        <= 11'd0;
            err_r       <= 1'b0;
            d_r         <= 11'd0;
            acc_r       <= 11'd0;
            k_r         <= 4'd10;
            out_valid_r <= 1'b0;
            out_x_r     <= 22'd0;
            out_err_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            r1_r        <= r1_s;
            r2_r        <= r2_s;
            err_r       <= err_s;
            d_r         <= d_s;
            acc_r       <= acc_s;
            k_r         <= k_s;
            out_valid_r <= out_valid_s;
            out_x_r     <= out_x_s;
            out_err_r   <= out_err_s;
        end
    end

    assign in_ready  = (state_r == IDLE);
    assign out_valid = out_valid_r;
    assign out_x     = out_x_r;
    assign out_err   = out_err_r;

endmodule

// File: tb/tb_crt_2011_2048_to_bin.sv
// Directed and random checks of the 2011/2048 CRT converter.
module tb_crt_2011_2048_to_bin;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] r1;
    logic [10:0] r2;
    logic        out_valid;
    logic        out_ready;
    logic [21:0] out_x;
    logic        out_err;

    int tests = 0;
    int fails = 0;
    int accepted = 0;
    int returned = 0;

    crt_2011_2048_to_bin dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .r1        (r1),
        .r2        (r2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full conversion: accept, measure latency, check result, hold, hand off.
    task automatic convert(input string tag, input logic [10:0] a, input logic [10:0] b,
                           input logic [21:0] ex, input logic ex_err, input int hold);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        r1 = a;
        r2 = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        accepted++;
        n = 0;
        while (!out_valid && n < 40) begin tick(); n++; end
        chk({tag, "_latency"}, n, 32'd12);
        chk({tag, "_x"}, {10'd0, out_x}, {10'd0, ex});
        chk({tag, "_err"}, {31'd0, out_err}, {31'd0, ex_err});
        repeat (hold) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        if (out_valid === 1'b0) returned++;
        chk({tag, "_handoff_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [21:0] hold_x;
        int          x;

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        r1 = 11'd0;
        r2 = 11'd0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_x",     {10'd0, out_x},     32'd0);
        chk("rst_out_err",   {31'd0, out_err},   32'd0);

        convert("x123456", 11'd785,  11'd576,  22'd123456,  1'b0, 0);
        convert("zero",    11'd0,    11'd0,    22'd0,       1'b0, 0);
        convert("max",     11'd2010, 11'd2047, 22'd4118527, 1'b0, 0);
        convert("r2_2011", 11'd0,    11'd2011, 22'd2011,    1'b0, 0);
        convert("illegal", 11'd2040, 11'd5,    22'd0,       1'b1, 0);
        convert("after_err", 11'd1000, 11'd1000, 22'd1000,  1'b0, 0);

        // Backpressure: DONE held 20 cycles while stray inputs are offered.
        r1 = 11'd785;
        r2 = 11'd576;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (12) tick();
        chk("bp_valid", {31'd0, out_valid}, 32'd1);
        hold_x = out_x;
        chk("bp_x", {10'd0, hold_x}, 32'd123456);
        for (int i = 0; i < 20; i++) begin
            r1 = 11'(i * 37);
            r2 = 11'(i * 91);
            in_valid = (i % 2 == 0);
            tick();
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_x",     {10'd0, out_x},     {10'd0, hold_x});
            chk("bp_hold_err",   {31'd0, out_err},   32'd0);
            chk("bp_hold_ready", {31'd0, in_ready},  32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release_ready", {31'd0, in_ready},  32'd1);
        chk("bp_release_valid", {31'd0, out_valid}, 32'd0);

        // Reset asserted at the edge of MUL step 5 (sixth edge after accept).
        r1 = 11'd785;
        r2 = 11'd576;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        repeat (15) tick();
        chk("mid_rst_no_output", {31'd0, out_valid}, 32'd0);
        convert("post_rst", 11'd785, 11'd576, 22'd123456, 1'b0, 0);

        // Random sweep with input and output gaps.
        for (int i = 0; i < 300; i++) begin
            x = int'($urandom_range(0, 4118527));
            repeat ($urandom_range(0, 3)) tick();
            convert("rand", 11'(x % 2011), 11'(x % 2048), 22'(x), 1'b0,
                    int'($urandom_range(0, 3)));
        end
        chk("in_out_count", returned, accepted);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
